// File: rtl/xinlv_frame_ctrl.sv
// Heart-rate frame parser: turns "BPM<digits>" byte frames from a UART receiver into a
// binary BPM value, with an inter-byte timeout and a saturating count of rejected frames.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for 'B'; every other byte is ignored silently
// S_GOT_B  | 'B' seen, expecting 'P'
// S_GOT_P  | "BP" seen, expecting 'M'
// S_DIGITS | "BPM" seen, accumulating up to MAX_DIGITS ASCII digits
module xinlv_frame_ctrl #(
   parameter int TIMEOUT_CYC = 208320,
   parameter int MAX_DIGITS  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] xinlv,
   output logic       xinlv_valid,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GOT_B  = 2'd1,
      S_GOT_P  = 2'd2,
      S_DIGITS = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    xinlv_q, xinlv_d;
   logic          xinlv_valid_q, xinlv_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic          is_b, is_p, is_m, is_digit;
   logic [9:0]    digit;
   logic [9:0]    acc_mac;
   logic          tmo_hit;
   logic          commit;
   logic          reject;
   logic [9:0]    commit_val;

   always_comb begin
      is_b     = (rx_data == 8'h42);
      is_p     = (rx_data == 8'h50);
      is_m     = (rx_data == 8'h4D);
      is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      digit    = {6'd0, rx_data[3:0]};
      acc_mac  = acc_q * 10'd10 + digit;
      // A byte arriving on the expiry cycle wins over the timeout
      tmo_hit  = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      commit     = 1'b0;
      reject     = 1'b0;
      commit_val = acc_q;

      if (rx_valid) begin
         unique case (state_q)
            S_IDLE: begin
               if (is_b) state_d = S_GOT_B;
            end
            S_GOT_B: begin
               if (is_p) begin
                  state_d = S_GOT_P;
               end else if (!is_b) begin
                  state_d = S_IDLE;
                  reject  = 1'b1;
               end
            end
            S_GOT_P: begin
               if (is_m) begin
                  state_d = S_DIGITS;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  reject  = 1'b1;
                  state_d = is_b ? S_GOT_B : S_IDLE;
               end
            end
            S_DIGITS: begin
               if (is_digit) begin
                  acc_d = acc_mac;
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == CNT_LAST) begin
                     commit     = 1'b1;
                     commit_val = acc_mac;
                     state_d    = S_IDLE;
                  end
               end else begin
                  // The terminating byte doubles as the start of the next header
                  if (cnt_q != '0) commit = 1'b1;
                  else             reject = 1'b1;
                  state_d = is_b ? S_GOT_B : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (tmo_hit) begin
         if ((state_q == S_DIGITS) && (cnt_q != '0)) commit = 1'b1;
         else                                        reject = 1'b1;
         state_d = S_IDLE;
      end
   end

   always_comb begin
      if (rx_valid || (state_q == S_IDLE) || tmo_hit) tmo_d = '0;
      else                                            tmo_d = tmo_q + TW'(1);

      xinlv_d = xinlv_q;
      if (commit) xinlv_d = (commit_val > 10'd255) ? 8'hFF : commit_val[7:0];

      err_cnt_d = err_cnt_q;
      if (reject && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

      xinlv_valid_d = commit;
      frame_err_d   = reject;
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         acc_q         <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         xinlv_q       <= '0;
         xinlv_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         xinlv_q       <= xinlv_d;
         xinlv_valid_q <= xinlv_valid_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign xinlv       = xinlv_q;
   assign xinlv_valid = xinlv_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;
   assign err_cnt     = err_cnt_q;

endmodule
